// File: rtl/spi_slave_rx_if.sv
// Bundles the SPI pins and the receive-side handshake of spi_slave_rx.
// The slave modport is the receiver's view. The master modport is the view of
// whatever drives the pins and consumes words, such as SPI_Master or a bench.
interface spi_slave_rx_if #(
   parameter int DW = 24
);
   logic          spi_en;
   logic          spi_clk;
   logic          spi_data;
   logic [DW-1:0] rx_data;
   logic          rx_valid;
   logic          rx_ready;
   logic          frame_err;
   logic          overrun;
   logic          clr_err;
   logic          busy;

   modport slave (
      input  spi_en, spi_clk, spi_data, rx_ready, clr_err,
      output rx_data, rx_valid, frame_err, overrun, busy
   );

   modport master (
      output spi_en, spi_clk, spi_data, rx_ready, clr_err,
      input  rx_data, rx_valid, frame_err, overrun, busy
   );
endinterface

// File: rtl/spi_slave_rx.sv
// 3-wire SPI receiver. It oversamples EN, CLK and DATA on the system clock and
// shifts DW bits MSB-first on each synchronized SPI_CLK rise. It then presents
// each complete word on a valid/ready output register. Frames of the wrong
// length raise a sticky frame_err. Words that arrive while the output is still
// full raise a sticky overrun.
module spi_slave_rx #(
   parameter int DW          = 24,
   parameter int SYNC_STAGES = 2
) (
   input  logic         clk,
   input  logic         RSTn,
   spi_slave_rx_if.slave bus
);

   localparam int             CW     = $clog2(DW + 1);
   localparam logic [CW-1:0]  DW_CNT = CW'(DW);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      CHECK = 2'd2
   } state_t;

   logic [SYNC_STAGES-1:0] en_sync;
   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] dat_sync;
   logic                   en_d;
   logic                   clk_d;
   logic                   en_s;
   logic                   clk_s;
   logic                   dat_s;
   logic                   en_fall;
   logic                   en_rise;
   logic                   clk_rise;

   state_t                 state;
   logic [CW-1:0]          bit_cnt;
   logic                   long_flag;
   logic [DW-1:0]          shreg;
   logic [DW-1:0]          rx_data;
   logic                   rx_valid;
   logic                   frame_err;
   logic                   overrun;
   logic                   busy;

   assign en_s     = en_sync[SYNC_STAGES-1];
   assign clk_s    = clk_sync[SYNC_STAGES-1];
   assign dat_s    = dat_sync[SYNC_STAGES-1];
   assign en_fall  = en_d & ~en_s;
   assign en_rise  = ~en_d & en_s;
   assign clk_rise = ~clk_d & clk_s;

   // Synchronize the pins and keep a one-cycle delayed copy for edge detection.
   // EN resets low so that a frame already in progress at reset release shows
   // no falling edge and is ignored.
   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         en_sync  <= '0;
         clk_sync <= '0;
         dat_sync <= '0;
         en_d     <= 1'b0;
         clk_d    <= 1'b0;
      end else begin
         en_sync  <= {en_sync[SYNC_STAGES-2:0], bus.spi_en};
         clk_sync <= {clk_sync[SYNC_STAGES-2:0], bus.spi_clk};
         dat_sync <= {dat_sync[SYNC_STAGES-2:0], bus.spi_data};
         en_d     <= en_s;
         clk_d    <= clk_s;
      end
   end

   // Frame FSM, shift register, output register and sticky flags.
   // Within one cycle a flag set overrides clr_err, and loading a new word
   // overrides the handshake clear of rx_valid.
   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         long_flag <= 1'b0;
         shreg     <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         if (rx_valid && bus.rx_ready) begin
            rx_valid <= 1'b0;
         end
         if (bus.clr_err) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (en_fall) begin
                  state     <= SHIFT;
                  busy      <= 1'b1;
                  bit_cnt   <= '0;
                  long_flag <= 1'b0;
               end
            end
            SHIFT: begin
               if (clk_rise) begin
                  if (bit_cnt < DW_CNT) begin
                     shreg   <= {shreg[DW-2:0], dat_s};
                     bit_cnt <= bit_cnt + CW'(1);
                  end else begin
                     long_flag <= 1'b1;
                  end
               end
               if (en_rise) begin
                  state <= CHECK;
               end
            end
            CHECK: begin
               state <= IDLE;
               busy  <= 1'b0;
               if ((bit_cnt == DW_CNT) && !long_flag) begin
                  if (!rx_valid || bus.rx_ready) begin
                     rx_data  <= shreg;
                     rx_valid <= 1'b1;
                  end else begin
                     overrun <= 1'b1;
                  end
               end else begin
                  frame_err <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.rx_data   = rx_data;
   assign bus.rx_valid  = rx_valid;
   assign bus.frame_err = frame_err;
   assign bus.overrun   = overrun;
   assign bus.busy      = busy;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx. It drives the pins with SPI_Master timing
// (3 clk high, 3 clk low) and checks words, flags and the handshake.
module tb_spi_slave_rx;

   logic clk;
   logic RSTn;
   int   checks;
   int   failures;
   logic [23:0] got[$];

   spi_slave_rx_if #(.DW(24)) bus ();

   spi_slave_rx #(.DW(24), .SYNC_STAGES(2)) dut (
      .clk  (clk),
      .RSTn (RSTn),
      .bus  (bus)
   );

   // 50 MHz system clock.
   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   // Record every word the consumer accepts, in the order it accepts them.
   // Sampling happens mid-low-phase, clear of both clock edges.
   always @(negedge clk) begin
      #5;
      if (bus.rx_valid === 1'b1 && bus.rx_ready === 1'b1) begin
         got.push_back(bus.rx_data);
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkWord(input string tag, input logic [23:0] exp);
      checkOutput({tag, "_count"}, got.size(), 1);
      if (got.size() > 0) begin
         checkOutput(tag, {8'h00, got.pop_front()}, {8'h00, exp});
      end
   endtask

   task automatic startFrame();
      @(negedge clk);
      bus.spi_en  = 1'b0;
      bus.spi_clk = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic shiftBits(input logic [23:0] word, input int first, input int count);
      for (int i = first; i < first + count; i++) begin
         if (i < 24) begin
            bus.spi_data = word[23 - i];
         end else begin
            bus.spi_data = 1'b1;
         end
         repeat (3) @(negedge clk);
         bus.spi_clk = 1'b1;
         repeat (3) @(negedge clk);
         bus.spi_clk = 1'b0;
      end
   endtask

   task automatic endFrame(input int gap);
      repeat (3) @(negedge clk);
      bus.spi_en = 1'b1;
      repeat (gap) @(negedge clk);
   endtask

   task automatic applyStimulus(input logic [23:0] word, input int nbits, input int gap);
      startFrame();
      shiftBits(word, 0, nbits);
      endFrame(gap);
   endtask

   task automatic pulseClrErr();
      @(negedge clk);
      bus.clr_err = 1'b1;
      @(negedge clk);
      bus.clr_err = 1'b0;
   endtask

   initial begin
      checks       = 0;
      failures     = 0;
      RSTn         = 1'b0;
      bus.spi_en   = 1'b1;
      bus.spi_clk  = 1'b0;
      bus.spi_data = 1'b0;
      bus.rx_ready = 1'b1;
      bus.clr_err  = 1'b0;

      // Reset state.
      repeat (3) @(negedge clk);
      checkOutput("reset_rx_data", {8'h00, bus.rx_data}, 32'h0);
      checkOutput("reset_rx_valid", bus.rx_valid, 1'b0);
      checkOutput("reset_frame_err", bus.frame_err, 1'b0);
      checkOutput("reset_overrun", bus.overrun, 1'b0);
      checkOutput("reset_busy", bus.busy, 1'b0);
      RSTn = 1'b1;
      repeat (5) @(negedge clk);
      checkOutput("post_reset_busy", bus.busy, 1'b0);

      // Test 1: a single word. rx_valid pulses once, on the 4th edge after EN rises.
      $display("[TB] test 1: single word A5C3F0");
      startFrame();
      shiftBits(24'hA5C3F0, 0, 24);
      checkOutput("t1_busy", bus.busy, 1'b1);
      endFrame(0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("t1_valid_edge3", bus.rx_valid, 1'b0);
      @(posedge clk);
      #1;
      checkOutput("t1_valid_edge4", bus.rx_valid, 1'b1);
      checkOutput("t1_rx_data", {8'h00, bus.rx_data}, 32'h00A5C3F0);
      @(posedge clk);
      #1;
      checkOutput("t1_valid_edge5", bus.rx_valid, 1'b0);
      repeat (4) @(negedge clk);
      checkWord("t1_word", 24'hA5C3F0);
      checkOutput("t1_frame_err", bus.frame_err, 1'b0);
      checkOutput("t1_busy_idle", bus.busy, 1'b0);

      // Test 2: two frames back to back with the minimum EN-high gap.
      $display("[TB] test 2: back-to-back frames");
      applyStimulus(24'h000001, 24, 4);
      applyStimulus(24'hFFFFFE, 24, 8);
      checkOutput("t2_count", got.size(), 2);
      if (got.size() == 2) begin
         checkOutput("t2_word0", {8'h00, got.pop_front()}, 32'h00000001);
         checkOutput("t2_word1", {8'h00, got.pop_front()}, 32'h00FFFFFE);
      end
      checkOutput("t2_frame_err", bus.frame_err, 1'b0);
      checkOutput("t2_overrun", bus.overrun, 1'b0);

      // Test 3: a short frame is flagged and dropped; the next good frame still arrives.
      $display("[TB] test 3: short frame");
      applyStimulus(24'h123456, 23, 8);
      checkOutput("t3_frame_err", bus.frame_err, 1'b1);
      checkOutput("t3_rx_valid", bus.rx_valid, 1'b0);
      checkOutput("t3_no_word", got.size(), 0);
      applyStimulus(24'h123456, 24, 8);
      checkWord("t3_word", 24'h123456);

      // Test 4: a long frame is flagged and dropped; clr_err clears the flag.
      $display("[TB] test 4: long frame");
      pulseClrErr();
      checkOutput("t4_pre_clear", bus.frame_err, 1'b0);
      applyStimulus(24'h800000, 25, 8);
      checkOutput("t4_frame_err", bus.frame_err, 1'b1);
      checkOutput("t4_no_word", got.size(), 0);
      pulseClrErr();
      checkOutput("t4_cleared", bus.frame_err, 1'b0);

      // Test 5: a second word arriving while the output is full sets overrun.
      $display("[TB] test 5: overrun");
      bus.rx_ready = 1'b0;
      applyStimulus(24'h111111, 24, 8);
      checkOutput("t5_valid1", bus.rx_valid, 1'b1);
      checkOutput("t5_data1", {8'h00, bus.rx_data}, 32'h00111111);
      checkOutput("t5_overrun0", bus.overrun, 1'b0);
      applyStimulus(24'h222222, 24, 8);
      checkOutput("t5_data_held", {8'h00, bus.rx_data}, 32'h00111111);
      checkOutput("t5_overrun1", bus.overrun, 1'b1);
      checkOutput("t5_valid_held", bus.rx_valid, 1'b1);
      bus.rx_ready = 1'b1;
      @(negedge clk);
      bus.rx_ready = 1'b0;
      checkOutput("t5_valid_cleared", bus.rx_valid, 1'b0);
      checkWord("t5_word", 24'h111111);
      pulseClrErr();
      checkOutput("t5_overrun_cleared", bus.overrun, 1'b0);
      bus.rx_ready = 1'b1;

      // Test 6: a reset in the middle of a frame loses the frame without an error.
      $display("[TB] test 6: reset mid-frame");
      startFrame();
      shiftBits(24'h5A5A5A, 0, 10);
      checkOutput("t6_busy_before", bus.busy, 1'b1);
      RSTn = 1'b0;
      #1;
      checkOutput("t6_busy_async", bus.busy, 1'b0);
      repeat (2) @(negedge clk);
      RSTn = 1'b1;
      shiftBits(24'h5A5A5A, 10, 14);
      endFrame(8);
      checkOutput("t6_no_word", got.size(), 0);
      checkOutput("t6_frame_err", bus.frame_err, 1'b0);
      checkOutput("t6_rx_valid", bus.rx_valid, 1'b0);
      applyStimulus(24'hABCDEF, 24, 8);
      checkWord("t6_word", 24'hABCDEF);
      checkOutput("t6_final_err", bus.frame_err, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
